countdown_reload_ctrl: RTL and testbench

Upstream control stage for the 4-bit countdown timer. Drives the timer's reload input `D` and watches its count `Q`. Accepts period/repeat configuration over a valid/ready handshake and launches a finite or continuous run of periods. Parks the timer at zero when idle, and reports each expiry, completion and remaining periods to the core.

---
 rtl/countdown_reload_ctrl_pkg.sv | 12 +
 rtl/countdown_reload_ctrl_cfg_shadow.sv | 36 +++
 rtl/countdown_reload_ctrl.sv | 131 +++++++++++++
 tb/tb_countdown_reload_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_reload_ctrl_pkg.sv
// Shared types and default widths for the countdown timer control slice.
package countdown_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    localparam int PW_DEF = 4;
    localparam int CW_DEF = 8;

endpackage

// File: rtl/countdown_reload_ctrl_cfg_shadow.sv
// Pending-period shadow register: holds one period written during a run until
// the next timer boundary consumes it, or a stop flushes it.
module cfg_shadow
    import countdown_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          consume,
    input  logic          flush,
    input  logic [PW-1:0] period,
    output logic          ready,
    output logic          pend_valid,
    output logic [PW-1:0] pend_period
);

    // A flush beats a same-cycle load so a stopping run never keeps stale config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_period <= '0;
        end else if (flush) begin
            pend_valid  <= 1'b0;
        end else if (load) begin
            pend_valid  <= 1'b1;
            pend_period <= period;
        end else if (consume) begin
            pend_valid  <= 1'b0;
        end
    end

    assign ready = !pend_valid;

endmodule

// File: rtl/countdown_reload_ctrl.sv
// Upstream control for the 4-bit countdown timer: drives its reload value D,
// watches Q, and runs finite or continuous sequences of periods.
module countdown_reload_ctrl
    import countdown_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_count,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] q_in,
    output logic [PW-1:0] d_out,
    output logic          busy,
    output logic          expired,
    output logic          done,
    output logic [CW-1:0] periods_left
);

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - CW'(1);
    endfunction

    ctrl_state_t   state, state_nxt;
    logic [PW-1:0] act_period;
    logic [CW-1:0] act_count;
    logic [CW-1:0] remaining, rem_nxt;
    logic          inflight, inflight_nxt;

    logic          pend_valid;
    logic [PW-1:0] pend_period;
    logic          pend_ready;

    logic          in_run;
    logic          boundary;
    logic          launch_ok;
    logic          cfg_hs;
    logic          idle_hs;
    logic [PW-1:0] eff_period;
    logic [CW-1:0] eff_count;
    logic          go;
    logic          stop_abort;
    logic          do_launch;
    logic          do_finish;

    assign in_run   = (state == RUN);
    assign boundary = in_run && (q_in == '0);

    // A zero pending period is a graceful-stop request rather than a period.
    assign launch_ok = ((act_count == '0) || (remaining != '0)) &&
                       (!pend_valid || (pend_period != '0));

    assign d_out     = (in_run && launch_ok) ? (pend_valid ? pend_period : act_period) : '0;
    assign cfg_ready = in_run ? pend_ready : 1'b1;

    assign cfg_hs     = cfg_valid && cfg_ready;
    assign idle_hs    = !in_run && cfg_hs;
    assign eff_period = idle_hs ? cfg_period : act_period;
    assign eff_count  = idle_hs ? cfg_count  : act_count;

    assign go         = !in_run && start && !abort && (eff_period != '0);
    assign stop_abort = in_run && abort;
    assign do_launch  = boundary && launch_ok && !abort;
    assign do_finish  = boundary && !launch_ok && !abort;

    cfg_shadow #(.PW(PW)) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (in_run && cfg_hs),
        .consume     (do_launch && pend_valid),
        .flush       (stop_abort || do_finish),
        .period      (cfg_period),
        .ready       (pend_ready),
        .pend_valid  (pend_valid),
        .pend_period (pend_period)
    );

    always_comb begin
        state_nxt    = state;
        rem_nxt      = remaining;
        inflight_nxt = inflight;
        if (go) begin
            state_nxt    = RUN;
            rem_nxt      = eff_count;
            inflight_nxt = 1'b0;
        end else if (stop_abort || do_finish) begin
            state_nxt    = IDLE;
            rem_nxt      = '0;
            inflight_nxt = 1'b0;
        end else if (do_launch) begin
            inflight_nxt = 1'b1;
            if (act_count != '0) begin
                rem_nxt = sat_dec(remaining);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            act_period   <= '0;
            act_count    <= '0;
            remaining    <= '0;
            inflight     <= 1'b0;
            busy         <= 1'b0;
            expired      <= 1'b0;
            done         <= 1'b0;
            periods_left <= '0;
        end else begin
            state    <= state_nxt;
            remaining <= rem_nxt;
            inflight <= inflight_nxt;
            if (idle_hs) begin
                act_period <= cfg_period;
                act_count  <= cfg_count;
            end else if (do_launch && pend_valid) begin
                act_period <= pend_period;
            end
            busy         <= (state_nxt == RUN);
            expired      <= boundary && inflight && !abort;
            done         <= do_finish;
            periods_left <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_reload_ctrl.sv
// Scoreboard bench for countdown_reload_ctrl driving a behavioural countdown timer.
module tb_countdown_reload_ctrl;

    localparam int PW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] q;
    logic [PW-1:0] d_out;
    logic          busy;
    logic          expired;
    logic          done;
    logic [CW-1:0] periods_left;

    always #5 clk = ~clk;

    countdown_reload_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_count    (cfg_count),
        .start        (start),
        .abort        (abort),
        .q_in         (q),
        .d_out        (d_out),
        .busy         (busy),
        .expired      (expired),
        .done         (done),
        .periods_left (periods_left)
    );

    // The timer being controlled: reloads D when it reaches zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= (q == '0) ? d_out : q - 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        int d;
        int rdy;
        int bsy;
        int ex;
        int dn;
        int left;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: a run is a list of periods; the shadow is a queue.
    bit m_run;
    int m_per, m_cnt, m_left;
    bit m_armed;
    int m_pend[$];
    bit m_ex, m_dn;

    function automatic bit m_ready();
        return !m_run || (m_pend.size() == 0);
    endfunction

    function automatic int m_next_load();
        int p;
        p = (m_pend.size() != 0) ? m_pend[0] : m_per;
        if (m_cnt != 0 && m_left == 0) return -1;
        if (p == 0) return -1;
        return p;
    endfunction

    task automatic m_reset();
        m_run = 0; m_per = 0; m_cnt = 0; m_left = 0; m_armed = 0;
        m_ex = 0; m_dn = 0;
        m_pend.delete();
        sb.delete();
    endtask

    task automatic m_step(input bit cv, input int cp, input int cc, input bit st, input bit ab);
        bit hs;
        int ld;
        hs = cv && m_ready();
        m_ex = 0;
        m_dn = 0;
        if (!m_run) begin
            if (hs) begin m_per = cp; m_cnt = cc; end
            if (st && !ab && m_per != 0) begin
                m_run = 1; m_left = m_cnt; m_armed = 0;
            end
        end else if (ab) begin
            m_run = 0; m_armed = 0; m_left = 0; m_pend.delete();
        end else begin
            if (q == 0) begin
                ld = m_next_load();
                m_ex = m_armed;
                if (ld < 0) begin
                    m_run = 0; m_dn = 1; m_armed = 0; m_left = 0; m_pend.delete();
                end else begin
                    if (m_pend.size() != 0) m_per = m_pend.pop_front();
                    if (m_cnt != 0) m_left--;
                    m_armed = 1;
                end
            end
            if (hs && m_run) m_pend.push_back(cp);
        end
    endtask

    task automatic cyc(input bit cv, input int cp, input int cc, input bit st, input bit ab);
        exp_t e;
        int ld;
        @(negedge clk);
        cfg_valid  = cv;
        cfg_period = PW'(cp);
        cfg_count  = CW'(cc);
        start      = st;
        abort      = ab;
        m_step(cv, cp, cc, st, ab);
        ld     = m_next_load();
        e.d    = (m_run && ld >= 0) ? ld : 0;
        e.rdy  = m_ready();
        e.bsy  = m_run;
        e.ex   = m_ex;
        e.dn   = m_dn;
        e.left = m_left;
        sb.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_d_out"}, d_out, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_expired"}, expired, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_periods_left"}, periods_left, 0);
    endtask

    // Monitor: outputs settle just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("d_out", d_out, mon_e.d);
                chk("cfg_ready", cfg_ready, mon_e.rdy);
                chk("busy", busy, mon_e.bsy);
                chk("expired", expired, mon_e.ex);
                chk("done", done, mon_e.dn);
                chk("periods_left", periods_left, mon_e.left);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        m_reset();
        #1 rst_n = 1'b0;
        #2 chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Finite run: period 3, two periods.
        cyc(1, 3, 2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle_cycles(14);

        // Continuous run with period 1, then abort.
        cyc(1, 1, 0, 1, 0);
        idle_cycles(20);
        cyc(0, 0, 0, 0, 1);
        idle_cycles(6);

        // Period change mid-run, then graceful stop via a zero period.
        cyc(1, 5, 0, 1, 0);
        idle_cycles(8);
        cyc(1, 2, 9, 0, 0);
        idle_cycles(12);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(8);

        // Edge cases: zero-period start, abort beating start.
        cyc(1, 0, 0, 1, 0);
        idle_cycles(3);
        cyc(1, 4, 1, 1, 1);
        idle_cycles(3);
        cyc(0, 0, 0, 1, 0);
        idle_cycles(8);

        // Asynchronous reset in the middle of a period.
        cyc(1, 7, 0, 1, 0);
        idle_cycles(4);
        @(negedge clk);
        cfg_valid = 0; start = 0; abort = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit cv, st, ab;
            int cp, cc;
            cv = ($urandom_range(0, 3) == 0);
            cp = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15);
            cc = $urandom_range(0, 3);
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 39) == 0);
            cyc(cv, cp, cc, st, ab);
        end
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
